// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the unified-memory arbiter.
// bus_err is present only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        bus_err;
`endif

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
`ifdef MEM_ARB_TIMEOUT_EN
    , output bus_err
`endif
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
`ifdef MEM_ARB_TIMEOUT_EN
    , input bus_err
`endif
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// BUSY wait counter for the memory arbiter; flags the cycle in which the
// transaction has waited TIMEOUT_CYCLES BUSY cycles without mem_ack.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW    = (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
  // Compared against the pre-increment count so the abort edge ends exactly
  // the TIMEOUT_CYCLES-th BUSY cycle.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store), data
// priority with a fetch starvation bound. Optional MEM_ARB_TIMEOUT_EN adds a BUSY abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t    state, state_nx;
  arb_owner_t    owner;
  logic [SW-1:0] streak;
  logic          grant_i, grant_d, done, abort, expired;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (grant_i | grant_d),
    .count_en ((state == ARB_BUSY) && !bus.mem_ack),
    .expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (bus.d_req && (!bus.i_req || streak < STREAK_MAX)) grant_d = 1'b1;
        else if (bus.i_req)                                   grant_i = 1'b1;
        if (grant_d || grant_i) state_nx = ARB_BUSY;
      end
      ARB_BUSY: begin
        // A mem_ack in the expiry cycle takes precedence over the abort.
        if (bus.mem_ack) begin
          done     = 1'b1;
          state_nx = ARB_RESP;
        end else if (expired) begin
          abort    = 1'b1;
          state_nx = ARB_RESP;
        end
      end
      ARB_RESP: state_nx = ARB_IDLE;
      default:  state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner         <= OWN_I;
      streak        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
`endif
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus.bus_err <= abort;
`endif
      if (grant_d || grant_i) begin
        owner         <= grant_d ? OWN_D : OWN_I;
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_d && bus.d_we;
        bus.mem_be    <= grant_d ? bus.d_be    : BE_WORD;
        bus.mem_addr  <= grant_d ? bus.d_addr  : bus.i_addr;
        bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
      end
      if (grant_i || (grant_d && !bus.i_req)) begin
        streak <= '0;
      end else if (grant_d && streak < STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
      if (done || abort) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        if (owner == OWN_D) begin
          bus.d_ack   <= 1'b1;
          bus.d_rdata <= done ? bus.mem_rdata : '0;
        end else begin
          bus.i_ack   <= 1'b1;
          bus.i_rdata <= done ? bus.mem_rdata : '0;
        end
      end
    end
  end

endmodule
